// File: rtl/cp0_intc_pkg.sv
// Shared CP0 definitions: register indices, SR/Cause field positions, ExcCode values.
package cp0_intc_pkg;

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 10;

    localparam logic [31:0] PRID_DEFAULT = 32'h4D43_5055;

    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } excCode_e;

endpackage

// File: rtl/cp0_intc.sv
// Coprocessor-0 interrupt/exception controller: SR, Cause, EPC, PRId, interrupt
// request/acknowledge handshake, synchronous exception capture and eret.
module cp0_intc
    import cp0_intc_pkg::*;
#(
    parameter logic [31:0] PRID = PRID_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:2]  HWInt,
    input  logic [4:0]  A,
    input  logic [31:0] DIn,
    input  logic        we,
    output logic [31:0] DOut,
    input  logic [31:2] epc_pc,
    input  logic        int_ack,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic        eret,
    output logic        int_req,
    output logic [31:2] EPC
);

    logic [5:0]  imReg;
    logic        ieReg;
    logic        exlReg;
    logic [5:0]  ipReg;
    logic [4:0]  excCodeReg;
    logic [31:2] epcReg;

    logic ackValid;
    logic excValid;
    logic srWrite;
    logic epcWrite;

    assign int_req  = (|(ipReg & imReg)) & ieReg & ~exlReg;
    assign ackValid = int_ack & int_req;
    assign excValid = exc_req & ~exlReg;
    assign srWrite  = we && (A == REG_SR);
    assign epcWrite = we && (A == REG_EPC);
    assign EPC      = epcReg;

    // IM/IE are only ever touched by mtc0; EXL, EPC and ExcCode follow the
    // ack > exception > eret > mtc0 priority, resolved per field.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imReg      <= '0;
            ieReg      <= 1'b0;
            exlReg     <= 1'b0;
            ipReg      <= '0;
            excCodeReg <= EXC_INT;
            epcReg     <= '0;
        end else begin
            ipReg <= HWInt;

            if (srWrite) begin
                imReg <= DIn[SR_IM_LO +: 6];
                ieReg <= DIn[SR_IE];
            end

            if (ackValid) begin
                exlReg     <= 1'b1;
                epcReg     <= epc_pc;
                excCodeReg <= EXC_INT;
            end else if (excValid) begin
                exlReg     <= 1'b1;
                epcReg     <= epc_pc;
                excCodeReg <= exc_code;
            end else begin
                if (eret) begin
                    exlReg <= 1'b0;
                end else if (srWrite) begin
                    exlReg <= DIn[SR_EXL];
                end
                if (epcWrite) begin
                    epcReg <= DIn[31:2];
                end
            end
        end
    end

    // Reads see the registered state only; a same-cycle mtc0 is not bypassed.
    always_comb begin
        DOut = '0;
        case (A)
            REG_SR: begin
                DOut[SR_IM_LO +: 6] = imReg;
                DOut[SR_EXL]        = exlReg;
                DOut[SR_IE]         = ieReg;
            end
            REG_CAUSE: begin
                DOut[CAUSE_IP_LO +: 6]  = ipReg;
                DOut[CAUSE_EXC_LO +: 5] = excCodeReg;
            end
            REG_EPC:  DOut = {epcReg, 2'b00};
            REG_PRID: DOut = PRID;
            default:  DOut = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_intc.sv
// Scoreboard bench for cp0_intc: expectations are queued alongside stimulus and
// drained against DOut / int_req / EPC after each clock edge.
module tb_cp0_intc;

    logic        clk;
    logic        rst_n;
    logic [7:2]  HWInt;
    logic [4:0]  A;
    logic [31:0] DIn;
    logic        we;
    logic [31:0] DOut;
    logic [31:2] epc_pc;
    logic        int_ack;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic        eret;
    logic        int_req;
    logic [31:2] EPC;

    int errCount   = 0;
    int checkCount = 0;

    localparam int SEL_DOUT = 0;
    localparam int SEL_IRQ  = 1;
    localparam int SEL_EPC  = 2;

    typedef struct {
        string       tag;
        int          sel;
        logic [4:0]  addr;
        logic [31:0] exp;
    } sbEntry_t;

    sbEntry_t sb[$];

    cp0_intc dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .HWInt    (HWInt),
        .A        (A),
        .DIn      (DIn),
        .we       (we),
        .DOut     (DOut),
        .epc_pc   (epc_pc),
        .int_ack  (int_ack),
        .exc_req  (exc_req),
        .exc_code (exc_code),
        .eret     (eret),
        .int_req  (int_req),
        .EPC      (EPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end else begin
            $display("check %s: got=%h", tag, got);
        end
    endtask

    task automatic expectVal(input string tag, input int sel, input logic [4:0] addr,
                             input logic [31:0] exp);
        sbEntry_t e;
        e.tag  = tag;
        e.sel  = sel;
        e.addr = addr;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic expReg(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        expectVal(tag, SEL_DOUT, addr, exp);
    endtask

    task automatic expIrq(input string tag, input logic exp);
        expectVal(tag, SEL_IRQ, 5'd0, {31'b0, exp});
    endtask

    task automatic expEpc(input string tag, input logic [31:0] exp);
        expectVal(tag, SEL_EPC, 5'd0, exp);
    endtask

    // Each entry takes 1 ns; callers keep at most 7 entries per drain so the
    // whole drain finishes before the next rising edge.
    task automatic drain();
        sbEntry_t e;
        logic [31:0] got;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            A = e.addr;
            #1;
            case (e.sel)
                SEL_DOUT: got = DOut;
                SEL_IRQ:  got = {31'b0, int_req};
                default:  got = {EPC, 2'b00};
            endcase
            check(e.tag, got, e.exp);
        end
    endtask

    task automatic clearStrobes();
        we      = 1'b0;
        int_ack = 1'b0;
        exc_req = 1'b0;
        eret    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clearStrobes();
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        A   = addr;
        DIn = data;
        we  = 1'b1;
        tick();
    endtask

    initial begin
        rst_n    = 1'b1;
        HWInt    = '0;
        A        = '0;
        DIn      = '0;
        epc_pc   = '0;
        exc_code = '0;
        clearStrobes();
        #1 rst_n = 1'b0;

        // 1: reset state
        expReg("rst_sr", 5'd12, 32'h0);
        expReg("rst_cause", 5'd13, 32'h0);
        expReg("rst_epc", 5'd14, 32'h0);
        expReg("rst_prid", 5'd15, 32'h4D43_5055);
        expReg("rst_other", 5'd3, 32'h0);
        expIrq("rst_irq", 1'b0);
        drain();
        @(negedge clk);
        rst_n = 1'b1;

        // 2: enable IM[2]/IE, raise HWInt[2]
        mtc0(5'd12, 32'h0000_0401);
        HWInt = 6'b000001;
        expReg("sr_write", 5'd12, 32'h0000_0401);
        expIrq("irq_before_ip", 1'b0);
        drain();
        tick();
        expReg("cause_ip", 5'd13, 32'h0000_0400);
        expIrq("irq_after_ip", 1'b1);
        drain();

        // 3: interrupt handshake, late ack, eret
        int_ack = 1'b1;
        epc_pc  = 30'h0000_0C05;
        tick();
        expReg("ack_epc", 5'd14, 32'h0000_3014);
        expEpc("ack_epc_port", 32'h0000_3014);
        expReg("ack_sr", 5'd12, 32'h0000_0403);
        expReg("ack_cause", 5'd13, 32'h0000_0400);
        expIrq("ack_irq_drop", 1'b0);
        drain();
        int_ack = 1'b1;
        epc_pc  = 30'h0000_0007;
        tick();
        expReg("late_ack_epc", 5'd14, 32'h0000_3014);
        drain();
        eret = 1'b1;
        tick();
        expIrq("eret_irq", 1'b1);
        expReg("eret_sr", 5'd12, 32'h0000_0401);
        drain();

        // 4: synchronous exception, then ignored nested exception
        exc_req  = 1'b1;
        exc_code = 5'd12;
        epc_pc   = 30'h100;
        tick();
        expReg("exc_cause", 5'd13, 32'h0000_0430);
        expReg("exc_epc", 5'd14, 32'h0000_0400);
        expIrq("exc_irq", 1'b0);
        drain();
        exc_req  = 1'b1;
        exc_code = 5'd4;
        epc_pc   = 30'h200;
        tick();
        expReg("exc2_cause", 5'd13, 32'h0000_0430);
        expReg("exc2_epc", 5'd14, 32'h0000_0400);
        drain();
        eret = 1'b1;
        tick();

        // 5: ack + exception + eret on the same edge
        int_ack  = 1'b1;
        exc_req  = 1'b1;
        exc_code = 5'd10;
        eret     = 1'b1;
        epc_pc   = 30'h55;
        tick();
        expReg("prio_sr", 5'd12, 32'h0000_0403);
        expReg("prio_cause", 5'd13, 32'h0000_0400);
        expReg("prio_epc", 5'd14, 32'h0000_0154);
        drain();
        eret = 1'b1;
        tick();

        // register write corners
        mtc0(5'd14, 32'hABCD_1237);
        mtc0(5'd13, 32'hFFFF_FFFF);
        mtc0(5'd3, 32'hFFFF_FFFF);
        expReg("mtc0_epc", 5'd14, 32'hABCD_1234);
        expReg("cause_ro", 5'd13, 32'h0000_0400);
        expReg("other_ro", 5'd3, 32'h0);
        drain();
        A       = 5'd12;
        DIn     = 32'h0000_0800;
        we      = 1'b1;
        int_ack = 1'b1;
        epc_pc  = 30'h9;
        tick();
        expReg("sr_with_ack", 5'd12, 32'h0000_0802);
        expReg("epc_with_ack", 5'd14, 32'h0000_0024);
        drain();

        // HWInt withdrawn before ack; late ack ignored
        mtc0(5'd12, 32'h0000_0401);
        expIrq("reenable_irq", 1'b1);
        drain();
        HWInt = 6'b000000;
        tick();
        expIrq("hw_drop_irq", 1'b0);
        expReg("hw_drop_cause", 5'd13, 32'h0);
        drain();
        int_ack = 1'b1;
        epc_pc  = 30'h3333;
        tick();
        expReg("stale_ack_sr", 5'd12, 32'h0000_0401);
        expReg("stale_ack_epc", 5'd14, 32'h0000_0024);
        drain();

        // 6: asynchronous reset mid-handshake
        HWInt = 6'b000001;
        tick();
        expIrq("pre_rst_irq", 1'b1);
        drain();
        rst_n = 1'b0;
        expIrq("async_rst_irq", 1'b0);
        expEpc("async_rst_epc", 32'h0);
        expReg("async_rst_sr", 5'd12, 32'h0);
        expReg("async_rst_cause", 5'd13, 32'h0);
        drain();
        @(negedge clk);
        rst_n   = 1'b1;
        int_ack = 1'b1;
        epc_pc  = 30'h3F;
        tick();
        expReg("post_rst_epc", 5'd14, 32'h0);
        expReg("post_rst_sr", 5'd12, 32'h0);
        expIrq("post_rst_irq", 1'b0);
        drain();

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule

// File: doc/cp0_intc.md
Name: cp0_intc

Overview:
Coprocessor-0 interrupt/exception controller sitting directly downstream of the memory-mapped device bridge; consumes the bridge's HWInt[7:2] lines.
- Holds SR, Cause, EPC and PRId.
- Raises a level interrupt request to the pipeline and captures the restart PC through a request/acknowledge handshake.
- Serves mfc0/mtc0 accesses and eret.

Parameters:
PRID, 32'h4D43_5055, value returned on reads of register 15.

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
HWInt  in  6 [7:2]  device interrupt lines from the bridge, level, clk domain
A  in  5  CP0 register index for mfc0/mtc0
DIn  in  32  mtc0 write data
we  in  1  mtc0 write strobe
DOut  out  32  mfc0 read data, combinational from A
epc_pc  in  30 [31:2]  restart PC presented with int_ack/exc_req
int_ack  in  1  pipeline accepts the pending interrupt this cycle
exc_req  in  1  synchronous exception taken this cycle
exc_code  in  5  ExcCode of the synchronous exception
eret  in  1  eret retiring this cycle
int_req  out  1  interrupt pending toward pipeline
EPC  out  30 [31:2]  current EPC, eret target

Behaviour:
- Reset (rst_n low, asynchronous): IM=0, IE=0, EXL=0, IP=0, ExcCode=0, EPC=0.
  - Consequently int_req=0 and EPC output =0.
  - DOut follows A combinationally: 0 except PRID at A=15.
- SR (index 12): IM at [15:10], EXL at [1], IE at [0]; all other bits read 0.
  - mtc0 to 12 writes IM, EXL and IE from the corresponding DIn bits.
- Cause (index 13): IP at [15:10], ExcCode at [6:2], other bits 0.
  - Read-only; mtc0 to 13 is ignored.
- EPC (index 14): {EPC, 2'b00}; mtc0 to 14 writes DIn[31:2].
- PRId (index 15): constant PRID, read-only.
- Other indices read 0; writes to them have no effect.
- Reads return pre-write (registered) values; no same-cycle bypass.
- IP <= HWInt every cycle, unconditionally. IP is level-sampled, not sticky; latency from HWInt to IP is 1 cycle.
- int_req = |(IP & IM) & IE & ~EXL, combinational from registers.
  - HWInt rising at edge N gives int_req high after edge N+1 (one register stage).
- Interrupt handshake: the pipeline asserts int_ack in a cycle where int_req=1, driving epc_pc. On that edge:
  - EXL<=1, EPC<=epc_pc, ExcCode<=0.
  - int_req drops in the next cycle.
  - int_ack while int_req=0 is ignored.
- Synchronous exception: exc_req=1 with EXL=0 gives EXL<=1, EPC<=epc_pc, ExcCode<=exc_code.
  - exc_req while EXL=1 is ignored (no EPC/ExcCode overwrite).
- eret=1 gives EXL<=0.
- Same-edge priority, highest first (for the EXL, EPC and ExcCode fields):
  1. int_ack (valid)
  2. exc_req
  3. eret
  4. mtc0
- mtc0 to SR in the same cycle as ack/exc still updates IM and IE; only EXL is overridden.
- mtc0 to EPC in the same cycle as ack/exc is lost.
- HWInt deasserting before ack: int_req falls; the pipeline must not ack afterwards, and a late ack is ignored.
- Reset asserted mid-handshake clears all state immediately, independent of clk.

Decomposition:
- Shared package:
  - register indices (SR=12, CAUSE=13, EPC=14, PRID=15)
  - SR/Cause field bit positions
  - ExcCode constants: Int=0, AdEL=4, AdES=5, RI=10, Ov=12
- No sub-module required; a single module of roughly 150–200 lines.

Test Plan:
1. Reset, then read A=12,13,14,15 -> 0, 0, 0, 32'h4D43_5055; int_req=0.
2. mtc0 SR=32'h0000_0401 (IM[2]=1, IE=1); HWInt=6'b000001 -> int_req=1 one cycle after IP latches; Cause reads 32'h0000_0400.
3. int_ack with epc_pc=30'h0000_0C05 -> EPC reads 32'h0000_3014, SR.EXL=1, ExcCode=0, int_req=0 next cycle with HWInt still high; eret -> int_req returns to 1.
4. exc_req with exc_code=12, epc_pc=30'h100, EXL=0 -> Cause=32'h0000_0030 (plus IP), EPC=32'h400; a second exc_req (code 4) with EXL=1 leaves EPC and ExcCode unchanged.
5. Same cycle int_ack + exc_req(code 10) + eret -> EXL=1, ExcCode=0, EPC=ack epc_pc.
6. rst_n low between int_req and int_ack, no clk edge -> all outputs 0 immediately; the ack after reset release is ignored.
